// File: rtl/link_scheduler.sv
// link_scheduler
// ------------------------------------------------------------------------------
// Sequences one command/reply exchange on a half-duplex link:
//   IDLE -> TX -> GUARD -> LISTEN -> RECEIVE -> T2 -> IDLE
// A single 16-bit down-counter times GUARD, LISTEN, RECEIVE (per bit) and T2.
// All outputs are registered. They change on the same edge as the state
// register, so each output always matches the state it is observed in.
//
// Optional feature (macro LINK_SCHEDULER_RETRY_EN):
//   defined   - a failed exchange is retransmitted up to MAX_RETRIES times
//               (T2 -> TX, no new cmd_ack). reply_fail pulses only once the
//               retries are used up.
//   undefined - every failure pulses reply_fail, and o_retry_cnt stays 0.
//
// Ports
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_cmd_req / o_cmd_ack  command handshake; i_reply_len is latched with ack
//   o_tx_en, i_tx_done     TX path enable, end-of-transmission pulse
//   o_rx_en                RX path enable (low holds the RX chain in reset)
//   i_preamble_detected    preamble pulse, accepted only in LISTEN
//   i_bit_vld, i_crc_ok    reply bit strobe, CRC result valid with last bit
//   o_reply_ok/o_reply_fail  one-cycle result pulses
//   o_retry_cnt            retransmissions used by the current command
//   o_busy                 high in every state except IDLE
//   o_state                debug view of the FSM state register
//
// Handshake: i_cmd_req is a request level that the requester holds until it
// sees o_cmd_ack. o_cmd_ack is a one-cycle pulse, issued only from IDLE, in
// the first TX cycle. The requester drops i_cmd_req once it sees the ack.
// i_cmd_req is ignored in every other state.
module link_scheduler #(
  parameter int T_GUARD     = 100,
  parameter int RX_TIMEOUT  = 2000,
  parameter int BIT_TIMEOUT = 200,
  parameter int T2_WAIT     = 300,
  parameter int MAX_RETRIES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_req,
  input  logic [7:0] i_reply_len,
  output logic       o_cmd_ack,
  output logic       o_tx_en,
  input  logic       i_tx_done,
  output logic       o_rx_en,
  input  logic       i_preamble_detected,
  input  logic       i_bit_vld,
  input  logic       i_crc_ok,
  output logic       o_reply_ok,
  output logic       o_reply_fail,
  output logic [1:0] o_retry_cnt,
  output logic       o_busy,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX      = 3'd1,
    S_GUARD   = 3'd2,
    S_LISTEN  = 3'd3,
    S_RECEIVE = 3'd4,
    S_T2      = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_bits;
  logic [7:0]  r_len;
  logic [1:0]  r_retry_cnt;
  logic        r_retry_pend;
  logic        r_cmd_ack;
  logic        r_tx_en;
  logic        r_rx_en;
  logic        r_reply_ok;
  logic        r_reply_fail;
  logic        r_busy;

  logic [7:0]  w_bits_next;
  logic        w_last;
  logic        w_fail;
  logic        w_can_retry;

  assign w_bits_next = r_bits + 8'd1;
  assign w_last      = (w_bits_next == r_len);

  // A strobe that arrives together with counter expiry wins over the
  // timeout, so the timeout terms require the strobe to be absent.
  assign w_fail = ((r_state == S_LISTEN) && !i_preamble_detected && (r_cnt == 16'd0)) ||
                  ((r_state == S_RECEIVE) &&
                   ((i_bit_vld && w_last && !i_crc_ok) ||
                    (!i_bit_vld && (r_cnt == 16'd0))));

`ifdef LINK_SCHEDULER_RETRY_EN
  assign w_can_retry = (r_retry_cnt < 2'(MAX_RETRIES));
`else
  assign w_can_retry = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 16'd0;
      r_bits       <= 8'd0;
      r_len        <= 8'd0;
      r_retry_cnt  <= 2'd0;
      r_retry_pend <= 1'b0;
      r_cmd_ack    <= 1'b0;
      r_tx_en      <= 1'b0;
      r_rx_en      <= 1'b0;
      r_reply_ok   <= 1'b0;
      r_reply_fail <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_cmd_ack    <= 1'b0;
      r_reply_ok   <= 1'b0;
      r_reply_fail <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_cmd_req) begin
            r_cmd_ack    <= 1'b1;
            r_len        <= i_reply_len;
            r_retry_cnt  <= 2'd0;
            r_retry_pend <= 1'b0;
            r_state      <= S_TX;
            r_tx_en      <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_TX: begin
          if (i_tx_done) begin
            r_state <= S_GUARD;
            r_tx_en <= 1'b0;
            r_cnt   <= 16'(T_GUARD - 1);
          end
        end
        S_GUARD: begin
          if (r_cnt == 16'd0) begin
            r_state <= S_LISTEN;
            r_rx_en <= 1'b1;
            r_cnt   <= 16'(RX_TIMEOUT - 1);
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_LISTEN: begin
          if (i_preamble_detected) begin
            if (r_len == 8'd0) begin
              // Zero-length reply: the preamble alone completes it.
              r_reply_ok <= 1'b1;
              r_state    <= S_T2;
              r_rx_en    <= 1'b0;
              r_cnt      <= 16'(T2_WAIT - 1);
            end else begin
              r_state <= S_RECEIVE;
              r_bits  <= 8'd0;
              r_cnt   <= 16'(BIT_TIMEOUT - 1);
            end
          end else if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_RECEIVE: begin
          if (i_bit_vld) begin
            r_bits <= w_bits_next;
            if (w_last) begin
              if (i_crc_ok) begin
                r_reply_ok <= 1'b1;
                r_state    <= S_T2;
                r_rx_en    <= 1'b0;
                r_cnt      <= 16'(T2_WAIT - 1);
              end
            end else begin
              r_cnt <= 16'(BIT_TIMEOUT - 1);
            end
          end else if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_T2: begin
          if (r_cnt == 16'd0) begin
            if (r_retry_pend) begin
              r_retry_pend <= 1'b0;
              r_state      <= S_TX;
              r_tx_en      <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx_en <= 1'b0;
          r_rx_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase

      // Failure handling is shared by LISTEN and RECEIVE. It comes after the
      // case statement so that it overrides the state and counter updates.
      if (w_fail) begin
        r_state <= S_T2;
        r_rx_en <= 1'b0;
        r_cnt   <= 16'(T2_WAIT - 1);
        if (w_can_retry) begin
          r_retry_cnt  <= r_retry_cnt + 2'd1;
          r_retry_pend <= 1'b1;
        end else begin
          r_reply_fail <= 1'b1;
        end
      end
    end
  end

  assign o_cmd_ack    = r_cmd_ack;
  assign o_tx_en      = r_tx_en;
  assign o_rx_en      = r_rx_en;
  assign o_reply_ok   = r_reply_ok;
  assign o_reply_fail = r_reply_fail;
  assign o_retry_cnt  = r_retry_cnt;
  assign o_busy       = r_busy;
  assign o_state      = r_state;

endmodule
